// File: rtl/mips32_run_ctrl.sv
//============================================================================
// Module      : mips32_run_ctrl
// Description : Run controller for the mips32 pipelined core. On start it
//               clears the register file, streams program words into
//               instruction memory (valid/ready), pulses the core control
//               reset, then runs the core until halt or watchdog expiry.
//               Optional feature macro: MIPS32_RUN_WATCHDOG_EN builds the
//               timeout_limit watchdog and the TIMEOUT outcome.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module mips32_run_ctrl #(
    parameter int MEM_AW    = 10,
    parameter int REG_COUNT = 32,
    parameter int TIMEOUT_W = 16
) (
    input  logic                 i_clk1,
    input  logic                 i_rst_n,
    input  logic                 i_cmd_start,
    input  logic                 i_prog_valid,
    output logic                 o_prog_ready,
    input  logic [31:0]          i_prog_data,
    input  logic                 i_prog_last,
    output logic                 o_imem_we,
    output logic [MEM_AW-1:0]    o_imem_addr,
    output logic [31:0]          o_imem_wdata,
    output logic                 o_rf_we,
    output logic [4:0]           o_rf_addr,
    output logic [31:0]          o_rf_wdata,
    output logic                 o_core_ctl_rst,
    output logic                 o_core_run,
    input  logic                 i_core_halted,
    input  logic [TIMEOUT_W-1:0] i_timeout_limit,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_timeout,
    output logic [31:0]          o_cycle_count,
    output logic [MEM_AW:0]      o_words_loaded
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CLR_RF  = 3'd1;
    localparam logic [2:0] S_LOAD    = 3'd2;
    localparam logic [2:0] S_CTL_RST = 3'd3;
    localparam logic [2:0] S_RUN     = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;
    localparam logic [2:0] S_TIMEOUT = 3'd6;

    localparam logic [4:0]        C_RF_LAST = 5'(REG_COUNT - 1);
    localparam logic [MEM_AW-1:0] C_PTR_MAX = '1;

    logic [2:0]        r_state;
    logic [4:0]        r_rf_addr;
    logic [MEM_AW-1:0] r_ptr;
    logic [MEM_AW:0]   r_words;
    logic [31:0]       r_cycles;

    logic w_start_ok;
    logic w_hs;
    logic w_load_end;
    logic w_wd_hit;

    // Start is honoured only from the resting states; busy states ignore it.
    assign w_start_ok = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_TIMEOUT);
    assign w_hs       = (r_state == S_LOAD) && i_prog_valid;
    // A full memory ends the load exactly like an explicit last word.
    assign w_load_end = w_hs && (i_prog_last || (r_ptr == C_PTR_MAX));

`ifdef MIPS32_RUN_WATCHDOG_EN
    logic [32:0] w_cyc_next;
    // Compare against the count this RUN cycle will leave behind, so a limit
    // of N stops the run after exactly N cycles.
    assign w_cyc_next = {1'b0, r_cycles} + 33'd1;
    assign w_wd_hit   = (i_timeout_limit != '0) && (w_cyc_next >= 33'(i_timeout_limit));
    assign o_timeout  = (r_state == S_TIMEOUT);
`else
    logic w_unused_limit;
    assign w_unused_limit = ^i_timeout_limit;
    assign w_wd_hit       = 1'b0;
    assign o_timeout      = 1'b0;
`endif

    // Sequencer state, clear/load pointers and run cycle counter.
    always_ff @(posedge i_clk1 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_rf_addr <= '0;
            r_ptr     <= '0;
            r_words   <= '0;
            r_cycles  <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_TIMEOUT: begin
                    if (i_cmd_start) begin
                        r_state   <= S_CLR_RF;
                        r_rf_addr <= '0;
                        r_ptr     <= '0;
                        r_words   <= '0;
                        r_cycles  <= '0;
                    end
                end
                S_CLR_RF: begin
                    if (r_rf_addr == C_RF_LAST) begin
                        r_state   <= S_LOAD;
                        r_rf_addr <= '0;
                    end else begin
                        r_rf_addr <= r_rf_addr + 5'd1;
                    end
                end
                S_LOAD: begin
                    if (w_hs) begin
                        r_ptr   <= r_ptr + MEM_AW'(1);
                        r_words <= r_words + (MEM_AW + 1)'(1);
                        if (w_load_end) begin
                            r_state <= S_CTL_RST;
                        end
                    end
                end
                S_CTL_RST: begin
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    if (r_cycles != 32'hFFFF_FFFF) begin
                        r_cycles <= r_cycles + 32'd1;
                    end
                    // Halt takes priority over a simultaneous watchdog hit.
                    if (i_core_halted) begin
                        r_state <= S_DONE;
                    end else if (w_wd_hit) begin
                        r_state <= S_TIMEOUT;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_prog_ready   = (r_state == S_LOAD);
    assign o_imem_we      = w_hs;
    assign o_imem_addr    = r_ptr;
    // Data is gated so the write bus stays quiet outside a handshake.
    assign o_imem_wdata   = w_hs ? i_prog_data : 32'd0;
    assign o_rf_we        = (r_state == S_CLR_RF);
    assign o_rf_addr      = r_rf_addr;
    assign o_rf_wdata     = 32'd0;
    assign o_core_ctl_rst = (r_state == S_CTL_RST);
    assign o_core_run     = (r_state == S_RUN);
    assign o_busy         = (r_state == S_CLR_RF) || (r_state == S_LOAD) ||
                            (r_state == S_CTL_RST) || (r_state == S_RUN);
    assign o_done         = (r_state == S_DONE);
    assign o_cycle_count  = r_cycles;
    assign o_words_loaded = r_words;

    logic w_unused_ok;
    assign w_unused_ok = w_start_ok;

endmodule

`default_nettype wire

// File: tb/tb_mips32_run_ctrl.sv
//============================================================================
// Module      : tb_mips32_run_ctrl
// Description : Randomized self-checking bench for mips32_run_ctrl. A
//               run-level model predicts clear, load, control-reset and run
//               outcomes from word counts, halt cycle and watchdog limit.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_mips32_run_ctrl;

    localparam int MEM_AW    = 10;
    localparam int REG_COUNT = 32;
    localparam int TIMEOUT_W = 16;
    localparam int MEM_WORDS = 1 << MEM_AW;
`ifdef MIPS32_RUN_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    logic                 clk1;
    logic                 rst_n;
    logic                 cmd_start;
    logic                 prog_valid;
    logic                 prog_ready;
    logic [31:0]          prog_data;
    logic                 prog_last;
    logic                 imem_we;
    logic [MEM_AW-1:0]    imem_addr;
    logic [31:0]          imem_wdata;
    logic                 rf_we;
    logic [4:0]           rf_addr;
    logic [31:0]          rf_wdata;
    logic                 core_ctl_rst;
    logic                 core_run;
    logic                 core_halted;
    logic [TIMEOUT_W-1:0] timeout_limit;
    logic                 busy;
    logic                 done;
    logic                 timeout;
    logic [31:0]          cycle_count;
    logic [MEM_AW:0]      words_loaded;

    int n_checks = 0;
    int n_errors = 0;

    mips32_run_ctrl #(
        .MEM_AW    (MEM_AW),
        .REG_COUNT (REG_COUNT),
        .TIMEOUT_W (TIMEOUT_W)
    ) u_dut (
        .i_clk1          (clk1),
        .i_rst_n         (rst_n),
        .i_cmd_start     (cmd_start),
        .i_prog_valid    (prog_valid),
        .o_prog_ready    (prog_ready),
        .i_prog_data     (prog_data),
        .i_prog_last     (prog_last),
        .o_imem_we       (imem_we),
        .o_imem_addr     (imem_addr),
        .o_imem_wdata    (imem_wdata),
        .o_rf_we         (rf_we),
        .o_rf_addr       (rf_addr),
        .o_rf_wdata      (rf_wdata),
        .o_core_ctl_rst  (core_ctl_rst),
        .o_core_run      (core_run),
        .i_core_halted   (core_halted),
        .i_timeout_limit (timeout_limit),
        .o_busy          (busy),
        .o_done          (done),
        .o_timeout       (timeout),
        .o_cycle_count   (cycle_count),
        .o_words_loaded  (words_loaded)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    // Absolute time bound so a stuck run still ends with a report.
    initial begin
        #3ms;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "bench time bound expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Step to just after the next rising edge.
    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_prog_ready"},  64'(prog_ready),   64'd0);
        check({tag, "_imem_we"},     64'(imem_we),      64'd0);
        check({tag, "_imem_addr"},   64'(imem_addr),    64'd0);
        check({tag, "_imem_wdata"},  64'(imem_wdata),   64'd0);
        check({tag, "_rf_we"},       64'(rf_we),        64'd0);
        check({tag, "_rf_addr"},     64'(rf_addr),      64'd0);
        check({tag, "_rf_wdata"},    64'(rf_wdata),     64'd0);
        check({tag, "_ctl_rst"},     64'(core_ctl_rst), 64'd0);
        check({tag, "_core_run"},    64'(core_run),     64'd0);
        check({tag, "_busy"},        64'(busy),         64'd0);
        check({tag, "_done"},        64'(done),         64'd0);
        check({tag, "_timeout"},     64'(timeout),      64'd0);
        check({tag, "_cycle_count"}, 64'(cycle_count),  64'd0);
        check({tag, "_words"},       64'(words_loaded), 64'd0);
    endtask

    // One complete start-to-outcome run. nwords > MEM_WORDS exercises the
    // memory-full exit. abort_at > 0 pulses rst_n in that RUN cycle.
    task automatic do_run(input int nwords, input int halt_at, input int limit,
                          input bit rand_valid, input int abort_at);
        logic [31:0] words[$];
        int  exp_words;
        int  widx;
        int  cyc;
        bit  v;
        bit  exp_to;
        int  exp_end;
        bit  run_ok;
        bit  cnt_ok;

        for (int i = 0; i < nwords; i++) words.push_back($urandom);
        exp_words = (nwords > MEM_WORDS) ? MEM_WORDS : nwords;
        exp_to    = WD_EN && (limit != 0) && (limit < halt_at);
        exp_end   = exp_to ? limit : halt_at;
        timeout_limit = TIMEOUT_W'(limit);

        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        #1;
        check("start_busy",    64'(busy),         64'd1);
        check("start_done",    64'(done),         64'd0);
        check("start_timeout", 64'(timeout),      64'd0);
        check("start_cycles",  64'(cycle_count),  64'd0);
        check("start_words",   64'(words_loaded), 64'd0);

        // Register clear: one address per cycle; stray starts must be ignored.
        for (int i = 0; i < REG_COUNT; i++) begin
            check("clr_rf_we",   64'(rf_we),   64'd1);
            check("clr_rf_addr", 64'(rf_addr), 64'(i));
            check("clr_run",     64'(core_run), 64'd0);
            tick();
            cmd_start = 1'($urandom_range(0, 1));
        end
        cmd_start = 1'b0;

        // Program load.
        widx = 0;
        cyc  = 0;
        while (widx < exp_words && cyc < 5000) begin
            v = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            prog_valid = v;
            prog_data  = words[widx];
            prog_last  = (widx == nwords - 1);
            #1;
            check("load_ready", 64'(prog_ready), 64'd1);
            check("load_we",    64'(imem_we),    64'(v));
            if (v) begin
                check("load_addr", 64'(imem_addr),  64'(widx));
                check("load_data", 64'(imem_wdata), 64'(words[widx]));
            end
            tick();
            if (v) widx++;
            cyc++;
        end
        check("load_progress", 64'(widx), 64'(exp_words));
        prog_valid = 1'b0;
        prog_last  = 1'b0;
        prog_data  = 32'd0;
        #1;
        check("ctl_ready", 64'(prog_ready),   64'd0);
        check("ctl_pulse", 64'(core_ctl_rst), 64'd1);
        check("ctl_run",   64'(core_run),     64'd0);
        check("ctl_words", 64'(words_loaded), 64'(exp_words));
        tick();

        // Run phase.
        run_ok = 1'b1;
        cnt_ok = 1'b1;
        for (int k = 1; k <= exp_end; k++) begin
            core_halted = (k >= halt_at);
            #1;
            if (core_run !== 1'b1 || core_ctl_rst !== 1'b0 || busy !== 1'b1) run_ok = 1'b0;
            if (cycle_count !== 32'(k - 1)) cnt_ok = 1'b0;
            if (k == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_zero("abort");
                core_halted = 1'b0;
                tick();
                rst_n = 1'b1;
                #1;
                check_zero("post_abort");
                return;
            end
            tick();
        end
        core_halted = 1'b0;
        #1;
        check("run_levels",  64'(run_ok),      64'd1);
        check("run_counter", 64'(cnt_ok),      64'd1);
        check("end_done",    64'(done),        64'(!exp_to));
        check("end_timeout", 64'(timeout),     64'(exp_to));
        check("end_run",     64'(core_run),    64'd0);
        check("end_busy",    64'(busy),        64'd0);
        check("end_cycles",  64'(cycle_count), 64'(exp_end));
        check("end_words",   64'(words_loaded), 64'(exp_words));
        // Outcome flag must hold while idle.
        tick();
        tick();
        check("hold_done",    64'(done),    64'(!exp_to));
        check("hold_timeout", 64'(timeout), 64'(exp_to));
    endtask

    initial begin
        rst_n         = 1'b0;
        cmd_start     = 1'b0;
        prog_valid    = 1'b0;
        prog_data     = 32'd0;
        prog_last     = 1'b0;
        core_halted   = 1'b0;
        timeout_limit = '0;
        tick();
        tick();
        #1;
        check_zero("reset");
        rst_n = 1'b1;
        tick();
        check_zero("idle");

        do_run(38,   500,  0,   1'b0, 0);   // bit-count sized program
        do_run(20,   50,   0,   1'b1, 0);   // gapped valid
        do_run(5,    300,  100, 1'b1, 0);   // watchdog limit 100
        do_run(3,    2000, 0,   1'b0, 0);   // limit 0 never expires
        do_run(4,    77,   77,  1'b1, 0);   // halt and limit together
        do_run(1,    40,   39,  1'b0, 0);   // minimum-length program
        do_run(1030, 10,   0,   1'b0, 0);   // memory-full exit
        for (int r = 0; r < 4; r++) begin
            do_run($urandom_range(1, 60), $urandom_range(1, 400),
                   $urandom_range(0, 400), 1'b1, 0);
        end
        do_run(10,   1000, 0,   1'b0, 25);  // reset mid-run
        do_run(7,    30,   0,   1'b1, 0);   // recovery after reset

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mips32_run_ctrl.md
# mips32_run_ctrl

Single-clock run controller that sequences a program run on the mips32 pipelined core. On a start command it zeroes the register file, streams program words into instruction memory over a valid/ready handshake, and clears core control state (pc, halted, taken_branch). It then enables the core, counts cycles until halt, and reports completion or watchdog timeout. It sits between the host/load path and the core's memory, register-file and control ports.

## Interface
- MEM_AW, 10, instruction memory address width in words
- REG_COUNT, 32, number of register-file entries to clear
- TIMEOUT_W, 16, width of watchdog limit
- clk1  input  1  clock, the core's primary phase
- rst_n  input  1  asynchronous active-low reset
- cmd_start  input  1  start pulse; sampled only in IDLE, DONE, TIMEOUT
- prog_valid  input  1  program word valid
- prog_ready  output  1  controller accepts program word
- prog_data  input  32  instruction word
- prog_last  input  1  marks final program word
- imem_we  output  1  instruction memory write enable
- imem_addr  output  MEM_AW  instruction memory write address
- imem_wdata  output  32  instruction memory write data
- rf_we  output  1  register-file write enable (clear)
- rf_addr  output  5  register-file write address
- rf_wdata  output  32  always 0
- core_ctl_rst  output  1  forces pc=0, halted=0, taken_branch=0
- core_run  output  1  core clock-enable
- core_halted  input  1  core halt flag
- timeout_limit  input  TIMEOUT_W  watchdog limit in RUN cycles; 0 disables
- busy  output  1  high in CLR_RF, LOAD, CTL_RST, RUN
- done  output  1  run ended by halt
- timeout  output  1  run ended by watchdog
- cycle_count  output  32  RUN cycles of the last/current run
- words_loaded  output  MEM_AW+1  words written in last load

## Operation
- States: IDLE, CLR_RF, LOAD, CTL_RST, RUN, DONE, TIMEOUT.
- IDLE/DONE/TIMEOUT + cmd_start=1: go to CLR_RF; clear done, timeout, cycle_count, words_loaded, load pointer.
- CLR_RF: rf_we=1, rf_addr counts 0..REG_COUNT-1, one per cycle; after address REG_COUNT-1, go to LOAD.
- LOAD: prog_ready=1. The handshake (prog_valid & prog_ready) writes combinationally: imem_we=1, imem_addr=pointer, imem_wdata=prog_data. Pointer and words_loaded increment.
- LOAD exit: a handshake with prog_last=1, or a handshake at pointer 2^MEM_AW-1 (memory full, treated as last), moves to CTL_RST. prog_ready drops the next cycle.
- CTL_RST: core_ctl_rst=1 for exactly one cycle, core_run=0; then RUN.
- RUN: core_run=1. cycle_count increments every RUN cycle, including the one where halt is sampled, and saturates at 0xFFFFFFFF.
  - core_halted=1: go to DONE.
  - Else, if watchdog is enabled and timeout_limit≠0 and cycle_count+1 ≥ timeout_limit: go to TIMEOUT.
  - Halt and limit in the same cycle: halt wins.
- DONE/TIMEOUT: core_run=0; the done or timeout flag is held until the next cmd_start.
- cmd_start while busy is ignored.

## Timing
- Reset (async, rst_n=0): state IDLE; every output 0, including counters and pointers.
- cmd_start is sampled at edge N; rf_we first asserts in cycle N+1.
- CLR_RF lasts REG_COUNT cycles. LOAD is at least one cycle per word. CTL_RST lasts 1 cycle.
- Minimum start-to-core_run latency: REG_COUNT+3 cycles for a 1-word program.
- done/timeout assert the cycle after the deciding RUN cycle; core_run is low in that same cycle.
- Reset asserted mid-run drops core_run immediately. The partial load is abandoned.

## Configuration
- MIPS32_RUN_WATCHDOG_EN defined: the timeout_limit comparison and the TIMEOUT state are built.
- Not defined: timeout is tied to 0, timeout_limit is ignored, and RUN waits for core_halted indefinitely.

## Test plan
- Reset then idle: all outputs 0, busy=0. A cmd_start pulse gives rf_we high for 32 cycles with rf_addr 0..31.
- Load the 38-word bit-count program, prog_valid held high, last on word 37: imem_addr 0..37, words_loaded=38, one core_ctl_rst pulse, then core_run=1.
- prog_valid toggles 1,0,1,0 during LOAD: only the handshake cycles write, addresses are contiguous, and no word is dropped or duplicated.
- Core model raises core_halted after 500 RUN cycles: done=1 and cycle_count=500; register r2 reads 4 in a full-core bench.
- Watchdog enabled, limit=100, halt never raised: timeout=1, cycle_count=100, core_run low. Same run with limit=0: never times out.
- Halt and limit reached in the same cycle give done=1, timeout=0. rst_n pulsed mid-RUN returns to IDLE with all outputs 0.
